// File: rtl/prod_accum_if.sv
// ---------------------------------------------------------------------------
// prod_accum_if
//
// Handshake bundle between the 8x8 multiplier stream, the prod_accum block
// and the result consumer.
//
// Parameters
//   ACC_W  accumulator / result width (17..32)
//   CNT_W  beat-counter width (2..16)
//
// Signals
//   in_valid   product beat valid                     (source -> accum)
//   in_ready   accumulator can take a beat            (accum  -> source)
//   in_prod    16-bit unsigned product                (source -> accum)
//   in_last    final beat of the vector               (source -> accum)
//   out_valid  result valid                           (accum  -> sink)
//   out_ready  sink accepts the result                (sink   -> accum)
//   out_sum    accumulated sum, ACC_W bits            (accum  -> sink)
//   out_count  beats in the vector, CNT_W bits        (accum  -> sink)
//   out_ovf    sum exceeded 2^ACC_W-1 in this vector  (accum  -> sink)
//
// Modports
//   master  the environment around the accumulator (source + sink)
//   slave   the accumulator itself
// ---------------------------------------------------------------------------
interface prod_accum_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_prod;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/prod_accum.sv
// ---------------------------------------------------------------------------
// prod_accum
//
// Streaming accumulator placed behind the 8x8 Dadda multiplier. Products are
// summed one per handshake until a beat flagged in_last is taken; the block
// then holds sum, beat count and overflow flag on the result handshake and
// clears itself once the result is consumed. Together with the multiplier
// this forms a dot-product / MAC datapath.
//
// Parameters
//   ACC_W  accumulator / result width, 17..32
//   CNT_W  beat-counter width, 2..16
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   prod_accum_if.slave: in_valid/in_ready/in_prod/in_last input
//         stream and out_valid/out_ready/out_sum/out_count/out_ovf result
//
// Configuration macro
//   PROD_ACCUM_SAT_EN  defined: on overflow the sum clamps at 2^ACC_W-1.
//                      undefined: the sum wraps modulo 2^ACC_W.
//   out_ovf is a sticky per-vector flag in both builds.
//
// Flow control
//   ACC  : in_ready=1, out_valid=0, one beat per cycle.
//   HOLD : in_ready=0, out_valid=1, outputs frozen until out_ready.
//   Both handshake outputs decode only the registered state, so there is no
//   combinational path from in_valid or out_ready to any output.
// ---------------------------------------------------------------------------
module prod_accum #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  prod_accum_if.slave  bus
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // -------------------------------------------------------------------------
  // Registers and their next values
  // -------------------------------------------------------------------------
  logic [0:0]       state,  state_d;
  logic [ACC_W-1:0] acc,    acc_d;
  logic [CNT_W-1:0] count,  count_d;
  logic             ovf,    ovf_d;

  logic             accept;
  logic             release_res;
  logic [ACC_W:0]   sum_ext;

  // One extra bit on the adder: its carry-out is the overflow indication.
  assign sum_ext = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, bus.in_prod};

  assign accept      = (state == ST_ACC)  && bus.in_valid;
  assign release_res = (state == ST_HOLD) && bus.out_ready;

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state;
    acc_d   = acc;
    count_d = count;
    ovf_d   = ovf;

    if (accept) begin
`ifdef PROD_ACCUM_SAT_EN
      // Once clamped, any further non-zero beat carries out again and
      // re-clamps, so the sum stays pinned for the rest of the vector.
      acc_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
      acc_d = sum_ext[ACC_W-1:0];
`endif
      if (sum_ext[ACC_W]) begin
        ovf_d = 1'b1;
      end
      // Saturating beat counter: a long vector reports CNT_MAX, not a wrap.
      if (count != CNT_MAX) begin
        count_d = count + CNT_W'(1);
      end
      if (bus.in_last) begin
        state_d = ST_HOLD;
      end
    end

    // A result release cannot coincide with an accept: accept needs ACC,
    // release needs HOLD.
    if (release_res) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      state_d = ST_ACC;
    end
  end

  // -------------------------------------------------------------------------
  // State registers (synchronous reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= ST_ACC;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      count <= count_d;
      ovf   <= ovf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: straight from registers
  // -------------------------------------------------------------------------
  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_sum   = acc;
  assign bus.out_count = count;
  assign bus.out_ovf   = ovf;

endmodule

// File: doc/prod_accum.md
# prod_accum

Streaming accumulator that sits directly downstream of the 8x8 Dadda multiplier. It takes the 16-bit unsigned products the multiplier produces, one per handshake, and sums them into a wide accumulator until a product marked last arrives. It then presents the finished sum, beat count and overflow flag on an output handshake, and clears itself for the next vector. This turns the combinational multiplier into a dot-product / MAC datapath.

## Interface
- ACC_W, 24, accumulator and result width in bits; legal range 17..32.
- CNT_W, 8, beat-counter width in bits; legal range 2..16.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  accumulator can accept a beat.
- in_prod  input  16  unsigned product from the multiplier.
- in_last  input  1  qualifies the beat as the final beat of the vector.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  accumulated sum.
- out_count  output  CNT_W  number of beats in the vector.
- out_ovf  output  1  sticky: the sum exceeded 2^ACC_W-1 at some point in the vector.

## Operation
- State machine with two states: ACC and HOLD. Reset state is ACC.
- **ACC state:**
  - in_ready=1 and out_valid=0.
  - An accept occurs when in_valid=1, i.e. in_valid&in_ready.
  - On accept: acc <= acc + zero-extended in_prod, computed at ACC_W+1 bits.
  - On accept: count <= count+1. The count saturates at 2^CNT_W-1 and never wraps.
  - On accept: if bit ACC_W of the sum is 1, ovf <= 1. The accumulator takes the low ACC_W bits, or the saturated value under the configuration macro.
  - An accept with in_last=1 moves the state to HOLD. The register updates for that beat happen in the same edge.
- **HOLD state:**
  - in_ready=0 and out_valid=1.
  - out_sum, out_count and out_ovf are driven directly from the acc, count and ovf registers, and stay stable while out_ready=0.
  - When out_valid&out_ready: acc, count and ovf are cleared to 0 and the state returns to ACC.
- in_valid in HOLD is ignored. The upstream source holds the beat, because in_ready=0.
- in_prod and in_last are don't-care when in_valid=0.
- rst=1 in any state, including mid-vector or in HOLD:
  - the next edge goes to ACC with acc=0, count=0, ovf=0;
  - partial sums are discarded.

## Timing
- Reset values of the outputs: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- in_ready and out_valid are decoded only from the registered state. There is no combinational path from in_valid or out_ready to any output.
- Latency: if the last beat is accepted at edge N, out_valid=1 in the cycle after edge N, and out_sum already includes that beat.
- Single-beat vector (in_last on the first beat): a result with out_count=1 appears one cycle later.
- Throughput: one beat per cycle in ACC.
- Each vector costs a minimum of 1 HOLD cycle. The first beat of the next vector is accepted at the earliest one cycle after the out handshake.
- A result handshake and a new input beat can never coincide, because in_ready=0 in HOLD.

## Configuration
- PROD_ACCUM_SAT_EN defined:
  - on overflow, acc is clamped to 2^ACC_W-1 and stays clamped for the rest of the vector;
  - ovf is set.
- PROD_ACCUM_SAT_EN not defined:
  - acc wraps modulo 2^ACC_W;
  - ovf is still set sticky.
- Every other behaviour is identical with and without the macro.

## Test plan
- **Basic sum.** ACC_W=24. Beats 0x0001, 0x00FF, 0xFE01 back-to-back, last on the third. The following are required one cycle after the third accept:
  - out_valid=1;
  - out_sum=0x00FF01;
  - out_count=3;
  - out_ovf=0.
- **Overflow.** ACC_W=17. Beats 0xFFFF×3, last on the third.
  - With the macro undefined: out_sum=0x0FFFD, out_ovf=1.
  - With PROD_ACCUM_SAT_EN defined: out_sum=0x1FFFF, out_ovf=1.
- **Backpressure.** out_ready is held 0 for 5 cycles in HOLD.
  - out_sum, out_count and out_ovf stay stable.
  - in_ready=0 throughout, and an offered in_valid beat is not consumed.
  - Once out_ready=1, the held beat is accepted as beat 1 of a fresh vector that starts from acc=0.
- **Gapped input.** ACC_W=24. Beats 0x0010, idle, idle, 0x0020 (last).
  - out_sum=0x000030 and out_count=2.
  - Idle cycles change nothing.
- **Reset mid-vector.** Accept 0x1234 and 0x0001 (not last), then assert rst for 1 cycle.
  - After reset: out_valid=0, out_sum=0, out_count=0, in_ready=1.
  - A following beat 0x0005 with in_last=1 gives out_sum=0x000005 and out_count=1.
- **Count saturation.** CNT_W=2. 5 beats of 0x0001, last on the fifth.
  - out_count=3 (saturated).
  - out_sum=0x000005.
